ddr_control_write_allmem: RTL and testbench
===========================================

# ddr_control_write_allmem

Avalon-MM burst-write master that fills a DDR address window with a deterministic, address-derived 64-bit pattern, then raises `test_complete`. It is the write-side counterpart of the all-memory read checker on the same `user0_avl` port. The read checker starts only when `test_complete` is high. Pacing matches the read side: fixed 4-beat bursts and a programmable idle gap between bursts.

## Interface
- `WR_STRADD`, 25'h000_0000: first burst base address (word address).
- `WR_ENDADD`, 25'h100_0000: last burst base address, inclusive. `WR_ENDADD - WR_STRADD` must be a multiple of 4.
- `GAP_CYCLES`, 100: idle cycles between bursts, range 0..255.
- `PATTERN_SEED`, 64'h0: XOR mask applied to every data beat.
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level input. Its rising edge launches a fill.
- `test_complete`  out  1  high once the last beat is accepted. Held until the next accepted start or reset.
- `busy`  out  1  high from launch until the last beat is accepted.
- `user0_avl_address`  out  25  burst base address.
- `user0_avl_write`  out  1  write request.
- `user0_avl_read`  out  1  tied 0.
- `user0_avl_writedata`  out  64  beat data.
- `user0_avl_beginbursttransfer`  out  1  first-cycle burst marker.
- `user0_avl_burstcount`  out  4  constant 4.
- `user0_avl_byteenable`  out  8  constant 8'hFF.
- `user0_avl_waitrequest`  in  1  **active-high ready**, i.e. waitrequest_n semantics. A beat is accepted on an edge where `write=1` and this input is 1.

## Operation
**Reset values** (all outputs registered): `address=WR_STRADD`, `write=0`, `beginbursttransfer=0`, `writedata=pattern(WR_STRADD)`, `test_complete=0`, `busy=0`, state IDLE.

**Start detection**
- `start` passes through two flops, r0 and r1.
- Launch condition `launch = r0 & ~r1`.

**States**
- IDLE
  - On `launch`: `address<=WR_STRADD`, `beat<=0`, `write<=1`, `beginbursttransfer<=1`, `busy<=1`, `test_complete<=0`. Go to BURST.
- BURST
  - `beginbursttransfer<=0` after its first cycle.
  - On each accepted beat: `beat<=beat+1`, and `writedata` updates to the next beat's pattern.
  - On acceptance of beat 3: `write<=0`, `gap<=GAP_CYCLES`.
    - If `address==WR_ENDADD`: go to DONE.
    - Otherwise: go to GAP.
  - While ready is low, `write`, `writedata` and `address` hold.
- GAP
  - While `gap!=0`: `gap<=gap-1`.
  - When `gap==0` and ready is 1: `address<=address+4`, `beat<=0`, `write<=1`, `beginbursttransfer<=1`. Go to BURST.
  - When `gap==0` and ready is 0: stay in GAP.
- DONE
  - `busy<=0`, `test_complete<=1`.
  - On `launch`: restart exactly as from IDLE.

**Pattern**
- Beat address `ba = address + beat`, 25 bits, wraps modulo 2^25.
- `pattern(ba) = {7'b0, ba, ~{7'b0, ba}} ^ PATTERN_SEED`.

**Boundary conditions**
- `launch` while BURST or GAP is ignored.
- Deasserting `start` mid-fill has no effect.
- Reset low at any edge forces the reset values on that edge, including mid-burst. A partial burst is abandoned.
- `WR_STRADD==WR_ENDADD` gives exactly one burst.
- `GAP_CYCLES=0`: the next burst begins one cycle after the previous burst's final beat.

## Timing
- `start` rising and sampled at edge k: `launch` is true in cycle k..k+1, and `write` and `beginbursttransfer` are high from edge k+1.
- Minimum burst duration is 4 cycles when ready is held at 1.
- The final acceptance at edge m gives `write=0` from edge m and `test_complete=1` from edge m+1.
- Writing a window of N bursts with ready held at 1 takes `N*4 + (N-1)*(GAP_CYCLES+1)` cycles from the first write cycle to the last accepted beat.

## Structure
- Shared package `ddr_test_pkg`:
  - `AVL_ADDR_W=25`, `AVL_DATA_W=64`, `BURST_LEN=4`.
  - Pattern function `ddr_pattern(ba, seed)`. The read checker reuses it for comparison.
  - State enum.
- No sub-module needed. The start edge detector stays inline.

## Test plan
- `WR_STRADD=0`, `WR_ENDADD=8`, `GAP_CYCLES=2`, ready held at 1, start pulse → 3 bursts at addresses 0, 4, 8; 12 beats; `test_complete` rises 1 cycle after the last beat; total span 12+2*3=18 cycles from first write.
- Beat at `ba=5`, seed 0 → `writedata=64'h00000005_FFFFFFFA`. With seed 64'hFFFF… → `64'hFFFFFFFA_00000005`.
- Ready held at 0 for 3 cycles during beat 2 → `write`, `writedata` and `address` are stable across all 3 cycles; beat 2 is accepted once; no beat is duplicated.
- A second start edge mid-fill → ignored. A start edge in DONE → `test_complete` drops, and the fill restarts at `WR_STRADD`.
- `rst_n=0` during beat 1 of burst 2 → next edge gives `write=0`, `busy=0`, `address=WR_STRADD`. A fresh start then gives a complete fill.
- `GAP_CYCLES=0`, ready held at 1 → exactly one idle cycle between consecutive bursts.

Source files
------------

// File: rtl/ddr_test_pkg.sv
// Shared definitions for the DDR all-memory write filler and its read checker:
// Avalon widths, burst length, FSM state encoding and the address-derived data pattern.
package ddr_test_pkg;

    localparam int AVL_ADDR_W = 25;
    localparam int AVL_DATA_W = 64;
    localparam int BURST_LEN  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Upper word carries the zero-extended beat address, lower word its complement.
    function automatic logic [AVL_DATA_W-1:0] ddr_pattern(
        input logic [AVL_ADDR_W-1:0] ba,
        input logic [AVL_DATA_W-1:0] seed
    );
        logic [31:0] word_s;
        word_s = {7'b0, ba};
        return {word_s, ~word_s} ^ seed;
    endfunction

endpackage

// File: rtl/ddr_control_write_allmem.sv
// Avalon-MM burst-write master: fills [WR_STRADD, WR_ENDADD] with 4-beat bursts of
// an address-derived pattern, spaced by GAP_CYCLES idle cycles, then flags completion.
module ddr_control_write_allmem
    import ddr_test_pkg::*;
#(
    parameter logic [AVL_ADDR_W-1:0] WR_STRADD    = 25'h000_0000,
    parameter logic [AVL_ADDR_W-1:0] WR_ENDADD    = 25'h100_0000,
    parameter logic [7:0]            GAP_CYCLES   = 8'd100,
    parameter logic [AVL_DATA_W-1:0] PATTERN_SEED = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  test_complete,
    output logic                  busy,
    output logic [AVL_ADDR_W-1:0] user0_avl_address,
    output logic                  user0_avl_write,
    output logic                  user0_avl_read,
    output logic [AVL_DATA_W-1:0] user0_avl_writedata,
    output logic                  user0_avl_beginbursttransfer,
    output logic [3:0]            user0_avl_burstcount,
    output logic [7:0]            user0_avl_byteenable,
    input  logic                  user0_avl_waitrequest
);

    localparam logic [1:0]            LAST_BEAT  = 2'(BURST_LEN - 1);
    localparam logic [AVL_ADDR_W-1:0] BURST_STEP = AVL_ADDR_W'(BURST_LEN);

    wr_state_e             state_r, state_s;
    logic [AVL_ADDR_W-1:0] address_r, address_s;
    logic [1:0]            beat_r, beat_s;
    logic [7:0]            gap_r, gap_s;
    logic                  write_r, write_s;
    logic                  bbt_r, bbt_s;
    logic [AVL_DATA_W-1:0] wdata_r, wdata_s;
    logic                  tc_r, tc_s;
    logic                  busy_r, busy_s;
    logic                  start_r0, start_r1;
    logic                  launch_s;
    logic                  accept_s;
    logic [AVL_ADDR_W-1:0] next_ba_s;

    // The waitrequest pin carries ready (waitrequest_n) semantics on this port.
    assign launch_s = start_r0 & ~start_r1;
    assign accept_s = write_r & user0_avl_waitrequest;

    // Two-flop start sampler feeding the rising-edge detector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_r0 <= 1'b0;
            start_r1 <= 1'b0;
        end else begin
            start_r0 <= start;
            start_r1 <= start_r0;
        end
    end

    // Next-state and next-output logic for the burst sequencer.
    always_comb begin
        state_s   = state_r;
        address_s = address_r;
        beat_s    = beat_r;
        gap_s     = gap_r;
        write_s   = write_r;
        bbt_s     = bbt_r;
        wdata_s   = wdata_r;
        tc_s      = tc_r;
        busy_s    = busy_r;
        next_ba_s = address_r + AVL_ADDR_W'(beat_r) + 25'd1;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (launch_s) begin
                    address_s = WR_STRADD;
                    beat_s    = 2'd0;
                    write_s   = 1'b1;
                    bbt_s     = 1'b1;
                    wdata_s   = ddr_pattern(WR_STRADD, PATTERN_SEED);
                    busy_s    = 1'b1;
                    tc_s      = 1'b0;
                    state_s   = ST_BURST;
                end else if (state_r == ST_DONE) begin
                    busy_s = 1'b0;
                    tc_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                bbt_s = 1'b0;
                if (accept_s) begin
                    beat_s  = beat_r + 2'd1;
                    wdata_s = ddr_pattern(next_ba_s, PATTERN_SEED);
                    if (beat_r == LAST_BEAT) begin
                        write_s = 1'b0;
                        gap_s   = GAP_CYCLES;
                        state_s = (address_r == WR_ENDADD) ? ST_DONE : ST_GAP;
                    end else begin
                        state_s = ST_BURST;
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            ST_GAP: begin
                if (gap_r != 8'd0) begin
                    gap_s = gap_r - 8'd1;
                end else if (user0_avl_waitrequest) begin
                    address_s = address_r + BURST_STEP;
                    beat_s    = 2'd0;
                    write_s   = 1'b1;
                    bbt_s     = 1'b1;
                    wdata_s   = ddr_pattern(address_r + BURST_STEP, PATTERN_SEED);
                    state_s   = ST_BURST;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                write_s = 1'b0;
                bbt_s   = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered Avalon outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            address_r <= WR_STRADD;
            beat_r    <= 2'd0;
            gap_r     <= 8'd0;
            write_r   <= 1'b0;
            bbt_r     <= 1'b0;
            wdata_r   <= ddr_pattern(WR_STRADD, PATTERN_SEED);
            tc_r      <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            address_r <= address_s;
            beat_r    <= beat_s;
            gap_r     <= gap_s;
            write_r   <= write_s;
            bbt_r     <= bbt_s;
            wdata_r   <= wdata_s;
            tc_r      <= tc_s;
            busy_r    <= busy_s;
        end
    end

    assign test_complete                = tc_r;
    assign busy                         = busy_r;
    assign user0_avl_address            = address_r;
    assign user0_avl_write              = write_r;
    assign user0_avl_read               = 1'b0;
    assign user0_avl_writedata          = wdata_r;
    assign user0_avl_beginbursttransfer = bbt_r;
    assign user0_avl_burstcount         = 4'(BURST_LEN);
    assign user0_avl_byteenable         = 8'hFF;

endmodule

// File: tb/tb_ddr_control_write_allmem.sv
// Scoreboard bench for ddr_control_write_allmem: two instances (gap 2 / seed 0 and
// gap 0 / seed all-ones) with directed fills, stalls, restart and mid-burst reset.
module tb_ddr_control_write_allmem;

    typedef struct packed {
        logic [24:0] addr;
        logic [63:0] data;
        logic        bbt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_b;
    logic ready_a, ready_b;

    logic        a_tc, a_busy, a_write, a_read, a_bbt;
    logic [24:0] a_addr;
    logic [63:0] a_data;
    logic [3:0]  a_bc;
    logic [7:0]  a_be;
    logic        b_tc, b_busy, b_write, b_read, b_bbt;
    logic [24:0] b_addr;
    logic [63:0] b_data;
    logic [3:0]  b_bc;
    logic [7:0]  b_be;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   wr_seen_a = 1'b0, wr_seen_b = 1'b0;
    int   first_wr_a, last_acc_a, first_wr_b, last_acc_b;

    ddr_control_write_allmem #(
        .WR_STRADD(25'd0), .WR_ENDADD(25'd8), .GAP_CYCLES(8'd2), .PATTERN_SEED(64'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .test_complete(a_tc), .busy(a_busy),
        .user0_avl_address(a_addr), .user0_avl_write(a_write), .user0_avl_read(a_read),
        .user0_avl_writedata(a_data), .user0_avl_beginbursttransfer(a_bbt),
        .user0_avl_burstcount(a_bc), .user0_avl_byteenable(a_be),
        .user0_avl_waitrequest(ready_a)
    );

    ddr_control_write_allmem #(
        .WR_STRADD(25'd1), .WR_ENDADD(25'd5), .GAP_CYCLES(8'd0),
        .PATTERN_SEED(64'hFFFF_FFFF_FFFF_FFFF)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .test_complete(b_tc), .busy(b_busy),
        .user0_avl_address(b_addr), .user0_avl_write(b_write), .user0_avl_read(b_read),
        .user0_avl_writedata(b_data), .user0_avl_beginbursttransfer(b_bbt),
        .user0_avl_burstcount(b_bc), .user0_avl_byteenable(b_be),
        .user0_avl_waitrequest(ready_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent bench model of the beat pattern.
    function automatic logic [63:0] exp_pat(input int ba, input logic [63:0] seed);
        logic [31:0] w;
        w = 32'(ba);
        return {w, ~w} ^ seed;
    endfunction

    task automatic push_a_fill();
        exp_t e;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                e.addr = 25'(4 * b);
                e.data = exp_pat(4 * b + k, 64'h0);
                e.bbt  = (k == 0);
                qa.push_back(e);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tc(input bit sel_b, input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if ((sel_b ? b_tc : a_tc) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tc_timeout: got no test_complete expected 1 (inst %0d)", sel_b);
        end
    endtask

    // Monitor A: every accepted beat is popped and compared against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && a_write === 1'b1) begin
            if (!wr_seen_a) begin
                wr_seen_a  = 1'b1;
                first_wr_a = cyc;
            end
            if (ready_a === 1'b1) begin
                last_acc_a = cyc;
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_unexpected_beat: got addr %h data %h expected none", a_addr, a_data);
                end else begin
                    e = qa.pop_front();
                    chk("a_beat_addr", 64'(a_addr), 64'(e.addr));
                    chk("a_beat_data", a_data, e.data);
                    chk("a_beat_bbt", 64'(a_bbt), 64'(e.bbt));
                end
            end
        end
    end

    // Monitor B: same scheme for the gap-0, all-ones-seed instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && b_write === 1'b1) begin
            if (!wr_seen_b) begin
                wr_seen_b  = 1'b1;
                first_wr_b = cyc;
            end
            if (ready_b === 1'b1) begin
                last_acc_b = cyc;
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected_beat: got addr %h data %h expected none", b_addr, b_data);
                end else begin
                    e = qb.pop_front();
                    chk("b_beat_addr", 64'(b_addr), 64'(e.addr));
                    chk("b_beat_data", b_data, e.data);
                    chk("b_beat_bbt", 64'(b_bbt), 64'(e.bbt));
                end
            end
        end
    end

    initial begin
        logic [63:0] b_tab [8];
        exp_t        e;
        int          at, acc;
        logic [24:0] s_addr;
        logic [63:0] s_data;

        b_tab[0] = 64'hFFFFFFFE_00000001; b_tab[1] = 64'hFFFFFFFD_00000002;
        b_tab[2] = 64'hFFFFFFFC_00000003; b_tab[3] = 64'hFFFFFFFB_00000004;
        b_tab[4] = 64'hFFFFFFFA_00000005; b_tab[5] = 64'hFFFFFFF9_00000006;
        b_tab[6] = 64'hFFFFFFF8_00000007; b_tab[7] = 64'hFFFFFFF7_00000008;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_write", 64'(a_write), 64'd0);
        chk("rst_bbt", 64'(a_bbt), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_tc", 64'(a_tc), 64'd0);
        chk("rst_addr", 64'(a_addr), 64'd0);
        chk("rst_data", a_data, 64'h00000000_FFFFFFFF);
        chk("rst_read", 64'(a_read), 64'd0);
        chk("rst_burstcount", 64'(a_bc), 64'd4);
        chk("rst_byteenable", 64'(a_be), 64'hFF);
        chk("rst_b_addr", 64'(b_addr), 64'd1);
        chk("rst_b_data", b_data, 64'hFFFFFFFE_00000001);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Instance B: two bursts at 1 and 5, gap 0, seed all-ones.
        for (int i = 0; i < 8; i++) begin
            e.addr = (i < 4) ? 25'd1 : 25'd5;
            e.data = b_tab[i];
            e.bbt  = (i % 4 == 0);
            qb.push_back(e);
        end
        start_b = 1'b1;
        wait_tc(1'b1, 100, at);
        start_b = 1'b0;
        chk("b_span", 64'(last_acc_b - first_wr_b + 1), 64'd9);
        chk("b_tc_delay", 64'(at - last_acc_b - 1), 64'd1);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        step(2);

        // Fill 1 on A, with a second start edge mid-fill that must be ignored.
        push_a_fill();
        wr_seen_a = 1'b0;
        start_a = 1'b1;
        step(8);
        start_a = 1'b0;
        step(3);
        start_a = 1'b1;
        @(negedge clk);
        chk("a_busy_midfill", 64'(a_busy), 64'd1);
        chk("a_tc_midfill", 64'(a_tc), 64'd0);
        wait_tc(1'b0, 200, at);
        chk("a_span", 64'(last_acc_a - first_wr_a + 1), 64'd18);
        chk("a_tc_delay", 64'(at - last_acc_a - 1), 64'd1);
        chk("a_busy_done", 64'(a_busy), 64'd0);
        chk("a_queue_empty1", 64'(qa.size()), 64'd0);
        step(5);
        @(negedge clk);
        chk("a_tc_held", 64'(a_tc), 64'd1);

        // Fill 2: restart from DONE, with a 3-cycle stall on beat 2.
        step(1);
        start_a = 1'b0;
        step(3);
        push_a_fill();
        start_a = 1'b1;
        step(1);
        @(posedge clk);
        @(negedge clk);
        chk("restart_tc", 64'(a_tc), 64'd0);
        chk("restart_write", 64'(a_write), 64'd1);
        chk("restart_addr", 64'(a_addr), 64'd0);
        acc = 1;
        for (int n = 0; n < 50 && acc < 2; n++) begin
            @(negedge clk);
            if (a_write === 1'b1 && ready_a === 1'b1) acc++;
        end
        @(posedge clk);
        #1 ready_a = 1'b0;
        @(negedge clk);
        s_addr = a_addr;
        s_data = a_data;
        chk("stall_write0", 64'(a_write), 64'd1);
        chk("stall_data_beat2", s_data, exp_pat(2, 64'h0));
        for (int n = 1; n < 3; n++) begin
            @(negedge clk);
            chk("stall_write", 64'(a_write), 64'd1);
            chk("stall_addr", 64'(a_addr), 64'(s_addr));
            chk("stall_data", a_data, s_data);
        end
        @(posedge clk);
        #1 ready_a = 1'b1;
        wait_tc(1'b0, 200, at);
        chk("a_queue_empty2", 64'(qa.size()), 64'd0);

        // Fill 3: reset during beat 1 of burst 2, then a fresh complete fill.
        step(1);
        start_a = 1'b0;
        step(3);
        for (int i = 0; i < 5; i++) begin
            e.addr = (i < 4) ? 25'd0 : 25'd4;
            e.data = exp_pat(i, 64'h0);
            e.bbt  = (i % 4 == 0);
            qa.push_back(e);
        end
        start_a = 1'b1;
        acc = 0;
        for (int n = 0; n < 100 && acc < 5; n++) begin
            @(negedge clk);
            if (a_write === 1'b1 && ready_a === 1'b1) acc++;
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        start_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_write", 64'(a_write), 64'd0);
        chk("midrst_busy", 64'(a_busy), 64'd0);
        chk("midrst_addr", 64'(a_addr), 64'd0);
        chk("midrst_queue", 64'(qa.size()), 64'd0);
        step(1);
        rst_n = 1'b1;
        step(2);
        push_a_fill();
        start_a = 1'b1;
        wait_tc(1'b0, 200, at);
        chk("a_queue_empty3", 64'(qa.size()), 64'd0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
